// File: rtl/multi_port_register_file_pkg.sv
// Shared types and default sizes for the datapath register file.
package rf_pkg;
  typedef enum logic [1:0] {RF_IDLE, RF_CLEAR, RF_DONE} rf_clr_state_e;
  localparam int RF_DATA_W = 16;
  localparam int RF_DEPTH  = 16;
endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: range check, array mux, write-first bypass, pending lookup.
module rf_read_port #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int BYPASS = 1
) (
  input  logic [ADDR_W-1:0]             addr,
  input  logic [DEPTH-1:0][DATA_W-1:0]  mem,
  input  logic [DEPTH-1:0]              pending,
  input  logic                          wr_acc,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          rsv_acc,
  input  logic [ADDR_W-1:0]             rsv_addr,
  output logic [DATA_W-1:0]             data,
  output logic                          pend
);
  // Compare against each entry rather than index, so out-of-range addresses fall through to 0.
  always_comb begin
    data = '0;
    pend = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_W'(i)) begin
        data = mem[i];
        pend = pending[i];
      end
    end
    if (BYPASS != 0 && wr_acc && wr_addr == addr) begin
      data = wr_data;
      if (!(rsv_acc && rsv_addr == addr)) pend = 1'b0;
    end
  end
endmodule

// File: rtl/multi_port_register_file.sv
// Register file: NUM_RD combinational reads, one synchronous write, pending scoreboard, clear sweep.
module multi_port_register_file
  import rf_pkg::*;
#(
  parameter int              DATA_W    = RF_DATA_W,
  parameter int              DEPTH     = RF_DEPTH,
  parameter int              NUM_RD    = 2,
  parameter int              BYPASS    = 1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  localparam int             ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       write_enable,
  input  logic [ADDR_W-1:0]          write_address,
  input  logic [DATA_W-1:0]          data_in,
  output logic                       write_ready,
  input  logic [NUM_RD*ADDR_W-1:0]   read_address,
  output logic [NUM_RD*DATA_W-1:0]   data_out,
  output logic [NUM_RD-1:0]          read_pending,
  input  logic                       rsv_enable,
  input  logic [ADDR_W-1:0]          rsv_address,
  input  logic                       clear_req,
  output logic                       clear_busy,
  output logic                       clear_done
);
  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [DEPTH-1:0]             pending;
  rf_clr_state_e                state;
  logic [ADDR_W-1:0]            clr_ptr;
  logic                         wr_acc, rsv_acc, idle;

  assign idle        = (state == RF_IDLE);
  assign write_ready = ~clear_busy;
  assign wr_acc      = write_enable & write_ready & (32'(write_address) < DEPTH);
  assign rsv_acc     = rsv_enable & idle & (32'(rsv_address) < DEPTH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
      pending    <= '0;
      state      <= RF_IDLE;
      clr_ptr    <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      // Reserve wins over a same-cycle write to the same entry.
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_acc && write_address == ADDR_W'(i)) begin
          mem[i]     <= data_in;
          pending[i] <= 1'b0;
        end
        if (rsv_acc && rsv_address == ADDR_W'(i)) pending[i] <= 1'b1;
      end
      case (state)
        RF_IDLE: begin
          clear_done <= 1'b0;
          if (clear_req) begin
            state      <= RF_CLEAR;
            clr_ptr    <= '0;
            clear_busy <= 1'b1;
          end
        end
        RF_CLEAR: begin
          for (int i = 0; i < DEPTH; i++) begin
            if (clr_ptr == ADDR_W'(i)) begin
              mem[i]     <= RESET_VAL;
              pending[i] <= 1'b0;
            end
          end
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
            state      <= RF_DONE;
            clear_done <= 1'b1;
          end
        end
        RF_DONE: begin
          state      <= RF_IDLE;
          clear_busy <= 1'b0;
          clear_done <= 1'b0;
        end
        default: begin
          state      <= RF_IDLE;
          clear_busy <= 1'b0;
          clear_done <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    rf_read_port #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BYPASS(BYPASS)
    ) u_rd (
      .addr     (read_address[k*ADDR_W +: ADDR_W]),
      .mem      (mem),
      .pending  (pending),
      .wr_acc   (wr_acc),
      .wr_addr  (write_address),
      .wr_data  (data_in),
      .rsv_acc  (rsv_acc),
      .rsv_addr (rsv_address),
      .data     (data_out[k*DATA_W +: DATA_W]),
      .pend     (read_pending[k])
    );
  end
endmodule

// File: tb/tb_multi_port_register_file.sv
// Directed bench: default config, no-bypass config and DEPTH=12 config share one stimulus stream.
module tb_multi_port_register_file;
  logic        clk = 1'b0, reset = 1'b1;
  logic        we = 1'b0, rsv = 1'b0, clr = 1'b0;
  logic [3:0]  wa = '0, ra0 = '0, ra1 = '0, rsa = '0;
  logic [15:0] din = '0;
  logic [7:0]  ra;
  logic [31:0] dout, dout_nb, dout12;
  logic [1:0]  pend, pend_nb, pend12;
  logic        wrdy, wrdy_nb, wrdy12, busy, busy_nb, busy12, done, done_nb, done12;
  int          errs = 0, checks = 0;

  assign ra = {ra1, ra0};
  always #5 clk = ~clk;

  multi_port_register_file u_dut (
    .clk(clk), .reset(reset), .write_enable(we), .write_address(wa), .data_in(din),
    .write_ready(wrdy), .read_address(ra), .data_out(dout), .read_pending(pend),
    .rsv_enable(rsv), .rsv_address(rsa), .clear_req(clr), .clear_busy(busy), .clear_done(done));
  multi_port_register_file #(.BYPASS(0)) u_nb (
    .clk(clk), .reset(reset), .write_enable(we), .write_address(wa), .data_in(din),
    .write_ready(wrdy_nb), .read_address(ra), .data_out(dout_nb), .read_pending(pend_nb),
    .rsv_enable(rsv), .rsv_address(rsa), .clear_req(clr), .clear_busy(busy_nb), .clear_done(done_nb));
  multi_port_register_file #(.DEPTH(12)) u_d12 (
    .clk(clk), .reset(reset), .write_enable(we), .write_address(wa), .data_in(din),
    .write_ready(wrdy12), .read_address(ra), .data_out(dout12), .read_pending(pend12),
    .rsv_enable(rsv), .rsv_address(rsa), .clear_req(clr), .clear_busy(busy12), .clear_done(done12));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 16; i++) begin
      ra0 = 4'(i); ra1 = 4'(i);
      #1;
      chk({tag, "_data"}, {16'h0, dout[15:0]}, 32'h0);
      chk({tag, "_pend"}, {31'h0, pend[1]}, 32'h0);
    end
  endtask

  task automatic fill();
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; wa = 4'(i); din = 16'h0100 + 16'(i);
      tick();
    end
    we = 1'b0;
  endtask

  initial begin
    int bcnt, dcnt;
    // 1. reset state
    ra0 = 4'd0; ra1 = 4'd15;
    #2;
    chk("rst_dout", dout, 32'h0);
    chk("rst_pend", {30'h0, pend}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_wrdy", {31'h0, wrdy}, 32'h1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // 2. write-first bypass vs registered read
    we = 1'b1; wa = 4'd3; din = 16'hBEEF; ra0 = 4'd3; ra1 = 4'd4;
    #1;
    chk("byp_same", {16'h0, dout[15:0]}, 32'hBEEF);
    chk("nobyp_same", {16'h0, dout_nb[15:0]}, 32'h0);
    tick();
    we = 1'b0;
    #1;
    chk("nobyp_next", {16'h0, dout_nb[15:0]}, 32'hBEEF);
    chk("byp_next", {16'h0, dout[15:0]}, 32'hBEEF);

    // 3. scoreboard
    rsv = 1'b1; rsa = 4'd5; ra1 = 4'd5;
    #1;
    chk("rsv_same", {30'h0, pend}, 32'h0);
    tick();
    rsv = 1'b0;
    #1;
    chk("rsv_next", {30'h0, pend}, 32'h2);
    we = 1'b1; wa = 4'd5; din = 16'h0055;
    #1;
    chk("wr_byp_pend", {31'h0, pend[1]}, 32'h0);
    chk("wr_nobyp_pend", {31'h0, pend_nb[1]}, 32'h1);
    chk("wr_byp_data", {16'h0, dout[31:16]}, 32'h0055);
    tick();
    we = 1'b0;
    #1;
    chk("wr_clr_pend", {31'h0, pend[1]}, 32'h0);
    we = 1'b1; wa = 4'd5; din = 16'h0066; rsv = 1'b1; rsa = 4'd5;
    tick();
    we = 1'b0; rsv = 1'b0;
    #1;
    chk("rsv_wins_pend", {31'h0, pend[1]}, 32'h1);
    chk("rsv_wins_data", {16'h0, dout[31:16]}, 32'h0066);

    // 5. out-of-range on DEPTH=12
    we = 1'b1; wa = 4'd13; din = 16'hAAAA; rsv = 1'b1; rsa = 4'd13; ra0 = 4'd13; ra1 = 4'd5;
    #1;
    chk("oor_same_data", {16'h0, dout12[15:0]}, 32'h0);
    chk("oor_same_pend", {31'h0, pend12[0]}, 32'h0);
    chk("inr_same_data", {16'h0, dout[15:0]}, 32'hAAAA);
    tick();
    we = 1'b0; rsv = 1'b0;
    #1;
    chk("oor_next_data", {16'h0, dout12[15:0]}, 32'h0);
    chk("oor_next_pend", {31'h0, pend12[0]}, 32'h0);
    chk("oor_other", {16'h0, dout12[31:16]}, 32'h0066);
    chk("inr_next_data", {16'h0, dout[15:0]}, 32'hAAAA);
    chk("inr_next_pend", {31'h0, pend[0]}, 32'h1);

    // 4. fill, then clear sweep (with a same-cycle reserve that the sweep must erase)
    fill();
    ra0 = 4'd7; ra1 = 4'd15;
    #1;
    chk("fill_7", {16'h0, dout[15:0]}, 32'h0107);
    chk("fill_15", {16'h0, dout[31:16]}, 32'h010F);
    clr = 1'b1; rsv = 1'b1; rsa = 4'd9;
    tick();
    clr = 1'b0; rsv = 1'b0;
    bcnt = 0; dcnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (!busy) break;
      bcnt++;
      if (done) dcnt++;
      if (c == 10) begin
        we = 1'b1; wa = 4'd2; din = 16'h1234;
        #1;
        chk("sweep_wrdy", {31'h0, wrdy}, 32'h0);
      end
      tick();
      we = 1'b0;
    end
    chk("sweep_busy_cycles", 32'(bcnt), 32'd17);
    chk("sweep_done_pulses", 32'(dcnt), 32'd1);
    chk("sweep_done_low", {31'h0, done}, 32'h0);
    chk("sweep_wrdy_back", {31'h0, wrdy}, 32'h1);
    check_all_zero("sweep");

    // 6. reset mid-sweep
    fill();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (6) tick();
    chk("mid_busy_pre", {31'h0, busy}, 32'h1);
    ra0 = 4'd10;
    #1;
    chk("mid_uncleared", {16'h0, dout[15:0]}, 32'h010A);
    reset = 1'b1;
    #1;
    chk("mid_busy", {31'h0, busy}, 32'h0);
    chk("mid_done", {31'h0, done}, 32'h0);
    chk("mid_wrdy", {31'h0, wrdy}, 32'h1);
    chk("mid_data", {16'h0, dout[15:0]}, 32'h0);
    tick();
    reset = 1'b0;
    dcnt = 0; bcnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) dcnt++;
      if (busy) bcnt++;
      tick();
    end
    chk("post_rst_done", 32'(dcnt), 32'd0);
    chk("post_rst_busy", 32'(bcnt), 32'd0);
    check_all_zero("post_rst");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
